// File: rtl/ibex_fetch_req_ctrl.sv
// Instruction fetch request controller: issues word-aligned bus requests, tracks
// outstanding responses and drops those belonging to a stream abandoned by a branch.
module ibex_fetch_req_ctrl #(
    parameter int unsigned NUM_REQS = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_i,
    input  logic                branch_i,
    input  logic [31:0]         addr_i,
    output logic                busy_o,
    output logic                instr_req_o,
    input  logic                instr_gnt_i,
    output logic [31:0]         instr_addr_o,
    input  logic                instr_rvalid_i,
    input  logic [31:0]         instr_rdata_i,
    input  logic                instr_err_i,
    output logic                fifo_clear_o,
    input  logic [NUM_REQS-1:0] fifo_busy_i,
    output logic                fifo_valid_o,
    output logic [31:0]         fifo_addr_o,
    output logic [31:0]         fifo_rdata_o,
    output logic                fifo_err_o
);

    localparam int unsigned CW = $clog2(NUM_REQS + 1);

    typedef enum logic {IDLE, WAIT_GNT} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] out_q, out_d;
    logic [CW-1:0] disc_q, disc_d;
    logic [31:0]   fetch_q, fetch_d;
    logic [30:0]   tgt_q, tgt_d;

    logic          branch, rvalid, gnt_acc, drop, room;
    logic [31:0]   br_addr;
    logic          unused_addr0;

    // Reset masks the external pulses so nothing leaks out while rst_i is high.
    assign branch       = branch_i & ~rst_i;
    assign rvalid       = instr_rvalid_i & ~rst_i;
    assign br_addr      = {addr_i[31:2], 2'b00};
    assign unused_addr0 = addr_i[0];

    // Room for one more word: FIFO must absorb out_q+1 words.
    always_comb begin
        room = 1'b0;
        for (int k = 0; k < int'(NUM_REQS); k++) begin
            if (out_q == CW'(k)) room = ~fifo_busy_i[k];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (instr_req_o && !instr_gnt_i) state_d = WAIT_GNT;
            WAIT_GNT: if (instr_gnt_i) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        instr_req_o = 1'b0;
        case (state_q)
            IDLE:     instr_req_o = branch | (req_i & room);
            WAIT_GNT: instr_req_o = 1'b1;
            default:  instr_req_o = 1'b0;
        endcase
        if (rst_i) instr_req_o = 1'b0;
    end

    assign gnt_acc      = instr_req_o & instr_gnt_i;
    assign instr_addr_o = branch ? br_addr : fetch_q;

    // A response in the branch cycle is always old-stream, even if disc_q is zero.
    assign drop         = branch | (disc_q != '0);
    assign fifo_valid_o = rvalid & ~drop;
    assign fifo_rdata_o = instr_rdata_i;
    assign fifo_err_o   = instr_err_i;
    assign fifo_addr_o  = {tgt_q, 1'b0};
    assign fifo_clear_o = branch;
    assign busy_o       = ~rst_i & ((out_q != '0) | (state_q == WAIT_GNT));

    always_comb begin
        fetch_d = fetch_q;
        if (gnt_acc)     fetch_d = instr_addr_o + 32'd4;
        else if (branch) fetch_d = br_addr;

        tgt_d = branch ? addr_i[31:1] : tgt_q;

        case ({gnt_acc, rvalid})
            2'b10:   out_d = out_q + CW'(1);
            2'b01:   out_d = out_q - CW'(1);
            default: out_d = out_q;
        endcase

        // A grant in the branch cycle is new-stream, so disc_q excludes it.
        disc_d = disc_q;
        if (branch)                      disc_d = rvalid ? out_q - CW'(1) : out_q;
        else if (rvalid && disc_q != '0) disc_d = disc_q - CW'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_q   <= '0;
            disc_q  <= '0;
            fetch_q <= '0;
            tgt_q   <= '0;
        end else begin
            out_q   <= out_d;
            disc_q  <= disc_d;
            fetch_q <= fetch_d;
            tgt_q   <= tgt_d;
        end
    end

    a_rvalid_outstanding: assert property (@(posedge clk_i) disable iff (rst_i)
        instr_rvalid_i |-> (out_q != '0));
    a_out_max: assert property (@(posedge clk_i) disable iff (rst_i)
        out_q <= CW'(NUM_REQS));
    a_disc_le_out: assert property (@(posedge clk_i) disable iff (rst_i)
        disc_q <= out_q);
    a_addr_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (state_q == WAIT_GNT && !branch_i && !instr_gnt_i) |=>
            (branch_i || instr_addr_o == $past(instr_addr_o)));

endmodule
